// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: 128-byte bus-written FIFO draining into an 8N1 UART serializer.
// Latency: push at edge N -> pop at N+1 -> start bit on uart_tx_o from N+2; status data one cycle after the read.
// Backpressure: none towards the bus; pushes while full are dropped and tx_buf_access_o stays low.
module uart_tx_buffer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        buf_rnw_i,
    output logic [31:0] rdata_o,
    output logic        tx_buffer_full_o,
    output logic        tx_buffer_empty_o,
    output logic        tx_buf_access_o,
    output logic        uart_tx_o,
    output logic        tx_busy_o
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [7:0]  mem [128];
    logic [7:0]  wr_ptr;
    logic [7:0]  rd_ptr;
    logic [7:0]  fifo_cnt;
    logic        sel;
    logic        push_vld;
    logic        stat_rd;
    logic        pop;
    logic        bit_done;
    tx_state_t   state;
    tx_state_t   state_nxt;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_dat;
    logic        unused_bits;

    assign sel               = (addr_i[18:16] == 3'h2);
    assign tx_buffer_full_o  = (rd_ptr[6:0] == wr_ptr[6:0]) && (rd_ptr[7] ^ wr_ptr[7]);
    assign tx_buffer_empty_o = (rd_ptr == wr_ptr);
    assign push_vld          = sel && !buf_rnw_i && !tx_buffer_full_o;
    assign stat_rd           = sel && buf_rnw_i;
    assign tx_buf_access_o   = push_vld || stat_rd;
    assign fifo_cnt          = wr_ptr - rd_ptr;
    assign bit_done          = (bit_cnt == 16'(CLKS_PER_BIT - 1));
    assign tx_busy_o         = (state != IDLE);
    assign unused_bits       = ^{addr_i[31:19], addr_i[15:0], wdata_i[31:8]};

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            mem[wr_ptr[6:0]] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr  <= 8'd0;
            rd_ptr  <= 8'd0;
            rdata_o <= 32'h0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 8'd1;
            if (pop)      rd_ptr <= rd_ptr + 8'd1;
            rdata_o <= stat_rd ? {24'h0, fifo_cnt} : 32'h0;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_buffer_empty_o) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_done) state_nxt = DATA;
            end
            DATA: begin
                if (bit_done && (bit_idx == 3'd7)) state_nxt = STOP;
            end
            STOP: begin
                // Chain straight into the next start bit so back-to-back frames have no gap.
                if (bit_done) begin
                    if (!tx_buffer_empty_o) begin
                        pop       = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            bit_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_dat <= 8'd0;
            uart_tx_o <= 1'b1;
        end else begin
            state <= state_nxt;

            if ((state_nxt != state) || bit_done || (state == IDLE)) bit_cnt <= 16'd0;
            else                                                       bit_cnt <= bit_cnt + 16'd1;

            if (state != DATA)  bit_idx <= 3'd0;
            else if (bit_done)  bit_idx <= bit_idx + 3'd1;

            if (pop)                             shift_dat <= mem[rd_ptr[6:0]];
            else if ((state == DATA) && bit_done) shift_dat <= {1'b0, shift_dat[7:1]};

            // Line level follows the current state, one cycle behind the state register.
            case (state)
                START:   uart_tx_o <= 1'b0;
                DATA:    uart_tx_o <= shift_dat[0];
                default: uart_tx_o <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed bench for uart_tx_buffer with a line receiver collecting frames.
// Latency: checks push->start-bit timing, frame length and status read timing cycle-exactly.
// Backpressure: exercises full/drop behaviour and pointer wrap across the 8-bit pointers.
module tb_uart_tx_buffer;
    localparam int CPB = 16;
    localparam logic [31:0] SEL_ADDR = 32'h0002_0000;

    logic        clk;
    logic        rst_n_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        buf_rnw_i;
    logic [31:0] rdata_o;
    logic        full;
    logic        empty;
    logic        access;
    logic        uart_tx_o;
    logic        tx_busy_o;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    logic [8:0] rx_q [$];

    uart_tx_buffer #(.CLKS_PER_BIT(CPB)) dut (
        .clk               (clk),
        .rst_n_i           (rst_n_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .buf_rnw_i         (buf_rnw_i),
        .rdata_o           (rdata_o),
        .tx_buffer_full_o  (full),
        .tx_buffer_empty_o (empty),
        .tx_buf_access_o   (access),
        .uart_tx_o         (uart_tx_o),
        .tx_busy_o         (tx_busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Line receiver: samples mid-bit, records {stop, data}.
    initial begin
        logic [8:0] fr;
        fr = 9'h0;
        forever begin
            @(negedge clk);
            if (rst_n_i === 1'b1 && uart_tx_o === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    fr[b] = uart_tx_o;
                end
                repeat (CPB) @(negedge clk);
                fr[8] = uart_tx_o;
                rx_q.push_back(fr);
            end
        end
    end

    task automatic bus_idle();
        addr_i    = 32'h0;
        wdata_i   = 32'h0;
        buf_rnw_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, output logic acc);
        addr_i    = SEL_ADDR;
        buf_rnw_i = 1'b0;
        wdata_i   = {24'h0, b};
        #1 acc = access;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic status_rd(output logic acc);
        addr_i    = SEL_ADDR;
        buf_rnw_i = 1'b1;
        #1 acc = access;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        int n;
        n = 0;
        while (!(tx_busy_o === 1'b0 && empty === 1'b1) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        ok = (tx_busy_o === 1'b0 && empty === 1'b1);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        bus_idle();
        repeat (3) @(negedge clk);
        vecs++; if (uart_tx_o !== 1'b1) begin errs++; $display("FAIL reset_tx got %b exp 1", uart_tx_o); end
        vecs++; if (tx_busy_o !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", tx_busy_o); end
        vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got %b exp 1", empty); end
        vecs++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full got %b exp 0", full); end
        vecs++; if (rdata_o !== 32'h0) begin errs++; $display("FAIL reset_rdata got %h exp 0", rdata_o); end
        vecs++; if (access !== 1'b0) begin errs++; $display("FAIL reset_access got %b exp 0", access); end
        rst_n_i = 1'b1;
        @(negedge clk);
        vecs++; if (empty !== 1'b1 || uart_tx_o !== 1'b1) begin
            errs++; $display("FAIL post_reset empty=%b tx=%b exp 1 1", empty, uart_tx_o);
        end
    endtask

    task automatic test_single();
        logic       acc;
        logic [9:0] frame_bits;
        int         nbad;
        logic       exp_busy;
        frame_bits = 10'b1101001010;
        rx_q.delete();
        push(8'hA5, acc);
        vecs++; if (acc !== 1'b1) begin errs++; $display("FAIL single_access got %b exp 1", acc); end
        vecs++; if (uart_tx_o !== 1'b1 || empty !== 1'b0) begin
            errs++; $display("FAIL single_n tx=%b empty=%b exp 1 0", uart_tx_o, empty);
        end
        @(negedge clk);
        vecs++; if (uart_tx_o !== 1'b1 || tx_busy_o !== 1'b1 || empty !== 1'b1) begin
            errs++; $display("FAIL single_pop tx=%b busy=%b empty=%b exp 1 1 1", uart_tx_o, tx_busy_o, empty);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            nbad = 0;
            for (int j = 0; j < CPB; j++) begin
                exp_busy = !(i == 9 && j == CPB - 1);
                if (uart_tx_o !== frame_bits[i] || tx_busy_o !== exp_busy) nbad++;
                @(negedge clk);
            end
            vecs++; if (nbad != 0) begin
                errs++; $display("FAIL single_bit%0d %0d cycles wrong, exp line %b", i, nbad, frame_bits[i]);
            end
        end
        vecs++; if (tx_busy_o !== 1'b0 || uart_tx_o !== 1'b1) begin
            errs++; $display("FAIL single_end busy=%b tx=%b exp 0 1", tx_busy_o, uart_tx_o);
        end
        vecs++; if (rx_q.size() != 1 || rx_q[0] !== 9'h1A5) begin
            errs++; $display("FAIL single_rx size=%0d first=%h exp 1 1a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        int   tp, t0, t1, n;
        bit   ok;
        rx_q.delete();
        push(8'h00, acc);
        tp = cyc;
        push(8'hFF, acc);
        t0 = -1000; t1 = -1000;
        n = 0;
        while (uart_tx_o !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        if (uart_tx_o === 1'b0) t0 = cyc;
        vecs++; if (t0 - tp != 2) begin errs++; $display("FAIL b2b_first_start got %0d exp 2", t0 - tp); end
        n = 0;
        while (uart_tx_o !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        n = 0;
        while (uart_tx_o !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        if (uart_tx_o === 1'b0) t1 = cyc;
        vecs++; if (t1 - t0 != 10 * CPB) begin
            errs++; $display("FAIL b2b_gap got %0d exp %0d", t1 - t0, 10 * CPB);
        end
        wait_idle(600, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL b2b_idle timeout busy=%b empty=%b", tx_busy_o, empty); end
        vecs++; if (rx_q.size() != 2) begin errs++; $display("FAIL b2b_rx_count got %0d exp 2", rx_q.size()); end
        else begin
            vecs++; if (rx_q[0] !== 9'h100 || rx_q[1] !== 9'h1FF) begin
                errs++; $display("FAIL b2b_rx_data got %h %h exp 100 1ff", rx_q[0], rx_q[1]);
            end
        end
    endtask

    task automatic test_status();
        logic       acc;
        bit         ok;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        rx_q.delete();
        push(8'h11, acc);
        repeat (2) @(negedge clk);
        status_rd(acc);
        vecs++; if (acc !== 1'b1 || rdata_o !== 32'h0) begin
            errs++; $display("FAIL status_zero acc=%b rdata=%h exp 1 0", acc, rdata_o);
        end
        for (int i = 1; i < 4; i++) begin
            push(exp_b[i], acc);
            vecs++; if (acc !== 1'b1) begin errs++; $display("FAIL status_push%0d access got %b exp 1", i, acc); end
        end
        addr_i = 32'h0003_0000; buf_rnw_i = 1'b0; wdata_i = 32'h55;
        #1;
        vecs++; if (access !== 1'b0) begin errs++; $display("FAIL unsel_push access got %b exp 0", access); end
        @(negedge clk);
        bus_idle();
        status_rd(acc);
        vecs++; if (rdata_o !== 32'h3) begin errs++; $display("FAIL status_three got %h exp 00000003", rdata_o); end
        @(negedge clk);
        vecs++; if (rdata_o !== 32'h0) begin errs++; $display("FAIL status_nonread got %h exp 0", rdata_o); end
        addr_i = 32'h0001_0000; buf_rnw_i = 1'b1;
        #1;
        vecs++; if (access !== 1'b0) begin errs++; $display("FAIL unsel_read access got %b exp 0", access); end
        @(negedge clk);
        bus_idle();
        vecs++; if (rdata_o !== 32'h0) begin errs++; $display("FAIL unsel_read_data got %h exp 0", rdata_o); end
        wait_idle(1000, ok);
        vecs++; if (!ok) begin errs++; $display("FAIL status_idle timeout busy=%b empty=%b", tx_busy_o, empty); end
        vecs++; if (rx_q.size() != 4) begin errs++; $display("FAIL status_rx_count got %0d exp 4", rx_q.size()); end
        for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
            vecs++; if (rx_q[i] !== {1'b1, exp_b[i]}) begin
                errs++; $display("FAIL status_rx%0d got %h exp %h", i, rx_q[i], {1'b1, exp_b[i]});
            end
        end
    endtask

    task automatic test_fill();
        logic acc;
        bit   ok;
        rx_q.delete();
        for (int i = 0; i < 130; i++) begin
            if (i == 128) begin
                vecs++; if (full !== 1'b0) begin errs++; $display("FAIL fill_early_full got %b exp 0", full); end
            end
            if (i == 129) begin
                vecs++; if (full !== 1'b1) begin errs++; $display("FAIL fill_full got %b exp 1", full); end
            end
            push(8'(i), acc);
            vecs++; if (acc !== (i < 129)) begin
                errs++; $display("FAIL fill_access%0d got %b exp %b", i, acc, (i < 129));
            end
        end
        status_rd(acc);
        vecs++; if (rdata_o !== 32'h80) begin errs++; $display("FAIL fill_count got %h exp 00000080", rdata_o); end
        wait_idle(129 * 10 * CPB + 400, ok);
        vecs++; if (!ok || full !== 1'b0) begin
            errs++; $display("FAIL fill_drain ok=%b full=%b exp 1 0", ok, full);
        end
        vecs++; if (rx_q.size() != 129) begin errs++; $display("FAIL fill_rx_count got %0d exp 129", rx_q.size()); end
        for (int i = 0; i < 129 && i < rx_q.size(); i++) begin
            vecs++; if (rx_q[i] !== {1'b1, 8'(i)}) begin
                errs++; $display("FAIL fill_rx%0d got %h exp %h", i, rx_q[i], {1'b1, 8'(i)});
            end
        end
    endtask

    task automatic test_wrap();
        logic       acc;
        bit         ok;
        logic [7:0] exp_q [$];
        logic [7:0] b;
        rx_q.delete();
        for (int i = 0; i < 130; i++) begin
            b = 8'((i * 7 + 3) & 255);
            push(b, acc);
            if (i < 129) exp_q.push_back(b);
            vecs++; if (acc !== (i < 129)) begin
                errs++; $display("FAIL wrap_access%0d got %b exp %b", i, acc, (i < 129));
            end
        end
        vecs++; if (full !== 1'b1 || empty !== 1'b0) begin
            errs++; $display("FAIL wrap_full full=%b empty=%b exp 1 0", full, empty);
        end
        wait_idle(129 * 10 * CPB + 400, ok);
        vecs++; if (!ok || full !== 1'b0) begin errs++; $display("FAIL wrap_drain1 ok=%b full=%b exp 1 0", ok, full); end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 12; i++) begin
                b = 8'(((k * 12 + i) * 13 + 1) & 255);
                push(b, acc);
                exp_q.push_back(b);
            end
            if (k == 0) repeat (3 * 10 * CPB) @(negedge clk);
        end
        wait_idle(40 * 10 * CPB, ok);
        vecs++; if (!ok || full !== 1'b0) begin errs++; $display("FAIL wrap_drain2 ok=%b full=%b exp 1 0", ok, full); end
        vecs++; if (rx_q.size() != exp_q.size()) begin
            errs++; $display("FAIL wrap_rx_count got %0d exp %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            vecs++; if (rx_q[i] !== {1'b1, exp_q[i]}) begin
                errs++; $display("FAIL wrap_rx%0d got %h exp %h", i, rx_q[i], {1'b1, exp_q[i]});
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic acc;
        push(8'h52, acc);
        push(8'h6B, acc);
        repeat (1 + 4 * CPB + CPB / 2) @(negedge clk);
        vecs++; if (uart_tx_o !== 1'b0 || tx_busy_o !== 1'b1) begin
            errs++; $display("FAIL midframe_bit3 tx=%b busy=%b exp 0 1", uart_tx_o, tx_busy_o);
        end
        rst_n_i = 1'b0;
        #1;
        vecs++; if (uart_tx_o !== 1'b1 || tx_busy_o !== 1'b0) begin
            errs++; $display("FAIL midframe_abort tx=%b busy=%b exp 1 0", uart_tx_o, tx_busy_o);
        end
        @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);
        vecs++; if (empty !== 1'b1 || full !== 1'b0 || tx_busy_o !== 1'b0 || uart_tx_o !== 1'b1) begin
            errs++; $display("FAIL midframe_release empty=%b full=%b busy=%b tx=%b exp 1 0 0 1",
                             empty, full, tx_busy_o, uart_tx_o);
        end
        repeat (4) @(negedge clk);
        vecs++; if (tx_busy_o !== 1'b0 || uart_tx_o !== 1'b1) begin
            errs++; $display("FAIL midframe_stays_idle busy=%b tx=%b exp 0 1", tx_busy_o, uart_tx_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_status();
        test_fill();
        test_wrap();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit period; legal range 2..65535.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 addr_i  input  32  bus address; TX buffer selected when addr_i[18:16] == 3'h2.
REQ-005 wdata_i  input  32  write data; only wdata_i[7:0] used.
REQ-006 buf_rnw_i  input  1  1 = read status, 0 = write (push) byte.
REQ-007 rdata_o  output  32  registered status read data.
REQ-008 tx_buffer_full_o  output  1  FIFO holds 128 bytes.
REQ-009 tx_buffer_empty_o  output  1  FIFO holds 0 bytes.
REQ-010 tx_buf_access_o  output  1  combinational; high for any cycle with a valid push or a status read.
REQ-011 uart_tx_o  output  1  serial line, 8N1, LSB first, idle high, registered.
REQ-012 tx_busy_o  output  1  serializer not in IDLE.

Function
REQ-013 The FIFO SHALL be 128 x 8 bits with 8-bit read/write pointers; index = ptr[6:0], ptr[7] is the wrap bit.
REQ-014 Full SHALL be (rd[6:0]==wr[6:0]) && (rd[7]^wr[7]); empty SHALL be rd==wr; both derived from registered pointers.
REQ-015 A valid push SHALL be: selected && !buf_rnw_i && !full; it writes wdata_i[7:0] at wr[6:0] and increments wr modulo 256.
REQ-016 A push while full SHALL be dropped: no pointer or memory change, tx_buf_access_o low.
REQ-017 A status read SHALL be: selected && buf_rnw_i; rdata_o the next cycle = {24'b0, count[7:0]} where count = wr - rd (0..128) before the edge.
REQ-018 In cycles without a status read, rdata_o SHALL load 32'h0.
REQ-019 The serializer FSM SHALL have states IDLE, START, DATA, STOP.
REQ-020 IDLE: uart_tx_o = 1; if !empty, pop the byte at rd[6:0] into an 8-bit shift register, increment rd, and enter START.
REQ-021 START SHALL drive 0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
REQ-022 DATA SHALL drive shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit, and enter STOP after bit 7.
REQ-023 STOP SHALL drive 1 for CLKS_PER_BIT cycles; at the end it SHALL pop and enter START directly if !empty, else enter IDLE.
REQ-024 A bit-period counter SHALL count 0..CLKS_PER_BIT-1 and clear on every state change.
REQ-025 A push and a pop in the same cycle SHALL both take effect; the count is unchanged.
REQ-026 A push into an empty FIFO with the FSM in IDLE at edge N SHALL cause the pop at edge N+1 and uart_tx_o = 0 from edge N+2.
REQ-027 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles; back-to-back frames SHALL have no idle gap.
REQ-028 Pointer wrap from 255 to 0 SHALL preserve correct full and empty detection.

Reset
REQ-029 While rst_n_i is low: rd = wr = 0, FSM = IDLE, counters = 0, shift register = 0, rdata_o = 0, uart_tx_o = 1, tx_busy_o = 0, empty = 1, full = 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, driving uart_tx_o high asynchronously.
REQ-031 FIFO memory contents SHALL not be reset.

Verification
REQ-032 Single byte, CLKS_PER_BIT=16: push 8'hA5 -> uart_tx_o sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles; tx_busy_o low after 160 cycles.
REQ-033 Fill: push 130 bytes 0..129 with the serializer held busy -> first byte is popped; 128 further bytes are accepted and full asserts; the last push is dropped; later frames carry 0..128 in order.
REQ-034 Back-to-back: push 8'h00 and 8'hFF consecutively -> second start bit begins exactly 160 cycles after the first; no idle gap.
REQ-035 Status: push 3 bytes while the serializer is busy -> the next status read returns 32'h3; a non-read cycle returns 32'h0.
REQ-036 Wrap: send 300 bytes total in bursts -> pointers wrap; empty/full stay correct; all bytes are serialized in order.
REQ-037 Reset mid-frame: assert rst_n_i low during DATA bit 3 -> uart_tx_o = 1 and tx_busy_o = 0 immediately; empty = 1 after release.
